// File: rtl/port_arbiter_if.sv
// Bus bundle between the input ports, the round-robin arbiter and the shared output.
// The slave side is the arbiter; the master side is whoever drives the requests
// and consumes the output packet.
interface port_arbiter_if #(
  parameter int NUM_IN = 4,
  parameter int SW     = 2
);
  logic [NUM_IN-1:0]    req_vld;
  logic [4*NUM_IN-1:0]  req_addr;
  logic [32*NUM_IN-1:0] req_payload;
  logic [NUM_IN-1:0]    granted;
  logic                 out_valid;
  logic [3:0]           out_addr;
  logic [31:0]          out_payload;
  logic [SW-1:0]        out_src;
  logic                 out_ready;
  logic [15:0]          pkt_count;

  modport slave (
    input  req_vld, req_addr, req_payload, out_ready,
    output granted, out_valid, out_addr, out_payload, out_src, pkt_count
  );

  modport master (
    output req_vld, req_addr, req_payload, out_ready,
    input  granted, out_valid, out_addr, out_payload, out_src, pkt_count
  );
endinterface

// File: rtl/port_arbiter.sv
// Round-robin arbiter moving one packet at a time from NUM_IN input ports onto a
// single output bus. Each packet goes IDLE -> SEND -> GRANT; the GRANT cycle keeps
// a freshly released port from being re-arbitrated while its granted pulse is high.
module port_arbiter #(
  parameter int NUM_IN = 4,
  parameter int SW     = 2
) (
  input logic          clock,
  input logic          reset_n,
  port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    GRANT = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [SW-1:0]     ptr_q;
  logic [SW-1:0]     sel;
  logic              found;
  logic              out_valid_q;
  logic [3:0]        out_addr_q;
  logic [31:0]       out_payload_q;
  logic [SW-1:0]     out_src_q;
  logic [NUM_IN-1:0] granted_q;
  logic [15:0]       pkt_count_q;

  // Pick the first requesting port at or above ptr, wrapping modulo NUM_IN.
  always_comb begin
    logic [SW-1:0] idx;
    sel   = ptr_q;
    found = 1'b0;
    idx   = ptr_q;
    for (int i = 0; i < NUM_IN; i++) begin
      idx = ptr_q + SW'(i);
      if (!found && bus.req_vld[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // Next-state decode: arbitrate in IDLE, wait for the handshake in SEND, one GRANT cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = SEND;
      SEND:    if (bus.out_ready) state_d = GRANT;
      GRANT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register plus all registered outputs, pointer and handshake counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      out_valid_q   <= 1'b0;
      out_addr_q    <= 4'h0;
      out_payload_q <= 32'h0;
      out_src_q     <= '0;
      granted_q     <= '0;
      pkt_count_q   <= 16'h0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          granted_q <= '0;
          if (found) begin
            out_valid_q   <= 1'b1;
            out_addr_q    <= bus.req_addr[{sel, 2'b00} +: 4];
            out_payload_q <= bus.req_payload[{sel, 5'b00000} +: 32];
            out_src_q     <= sel;
          end
        end
        SEND: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            granted_q   <= NUM_IN'(1) << out_src_q;
            ptr_q       <= out_src_q + SW'(1);
            pkt_count_q <= pkt_count_q + 16'd1;
          end
        end
        GRANT: begin
          granted_q <= '0;
        end
        default: begin
          granted_q   <= '0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_addr    = out_addr_q;
  assign bus.out_payload = out_payload_q;
  assign bus.out_src     = out_src_q;
  assign bus.granted     = granted_q;
  assign bus.pkt_count   = pkt_count_q;

endmodule

// File: tb/tb_port_arbiter.sv
// Directed bench for port_arbiter: a vector table for the basic packet flow, then
// hand-written sequences for round robin, backpressure, reset mid-SEND and counter wrap.
module tb_port_arbiter;

  logic clock;
  logic reset_n;
  int   n_compared;
  int   n_mismatched;

  port_arbiter_if #(.NUM_IN(4), .SW(2)) bus ();

  port_arbiter #(.NUM_IN(4), .SW(2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [3:0]   vld;
    logic [15:0]  addr;
    logic [127:0] payload;
    logic         ready;
    logic         exp_valid;
    logic [3:0]   exp_granted;
    logic [3:0]   exp_addr;
    logic [31:0]  exp_payload;
    logic [1:0]   exp_src;
    logic [15:0]  exp_count;
  } vec_t;

  vec_t vecs[11];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic apply_stimulus(input logic [3:0] vld, input logic [15:0] addr,
                                input logic [127:0] payload, input logic ready);
    bus.req_vld     = vld;
    bus.req_addr    = addr;
    bus.req_payload = payload;
    bus.out_ready   = ready;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic check_all(input string tag, input logic valid, input logic [3:0] granted,
                           input logic [3:0] addr, input logic [31:0] payload,
                           input logic [1:0] src, input logic [15:0] count);
    check_output({tag, " out_valid"},   32'(bus.out_valid),   32'(valid));
    check_output({tag, " granted"},     32'(bus.granted),     32'(granted));
    check_output({tag, " out_addr"},    32'(bus.out_addr),    32'(addr));
    check_output({tag, " out_payload"}, bus.out_payload,      payload);
    check_output({tag, " out_src"},     32'(bus.out_src),     32'(src));
    check_output({tag, " pkt_count"},   32'(bus.pkt_count),   32'(count));
  endtask

  task automatic do_reset();
    apply_stimulus(4'b0000, 16'h0, 128'h0, 1'b0);
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [127:0] p_a;
    logic [127:0] p_b;
    logic [3:0]   mask;
    int           grant_idx;

    n_compared   = 0;
    n_mismatched = 0;
    reset_n      = 1'b1;
    p_a = {32'h0, 32'hDEADBEEF, 64'h0};
    p_b = {32'h33330003, 64'h0, 32'h11110000};

    vecs[0]  = '{4'b0000, 16'h0000, 128'h0, 1'b1, 1'b0, 4'b0000, 4'h0, 32'h00000000, 2'd0, 16'd0};
    vecs[1]  = '{4'b0100, 16'h0A00, p_a,    1'b1, 1'b1, 4'b0000, 4'hA, 32'hDEADBEEF, 2'd2, 16'd0};
    vecs[2]  = '{4'b0000, 16'h0000, 128'h0, 1'b1, 1'b0, 4'b0100, 4'hA, 32'hDEADBEEF, 2'd2, 16'd1};
    vecs[3]  = '{4'b1001, 16'h3001, p_b,    1'b1, 1'b0, 4'b0000, 4'hA, 32'hDEADBEEF, 2'd2, 16'd1};
    vecs[4]  = '{4'b1001, 16'h3001, p_b,    1'b1, 1'b1, 4'b0000, 4'h3, 32'h33330003, 2'd3, 16'd1};
    vecs[5]  = '{4'b1001, 16'h3001, p_b,    1'b1, 1'b0, 4'b1000, 4'h3, 32'h33330003, 2'd3, 16'd2};
    vecs[6]  = '{4'b0001, 16'h3001, p_b,    1'b1, 1'b0, 4'b0000, 4'h3, 32'h33330003, 2'd3, 16'd2};
    vecs[7]  = '{4'b0001, 16'h3001, p_b,    1'b1, 1'b1, 4'b0000, 4'h1, 32'h11110000, 2'd0, 16'd2};
    vecs[8]  = '{4'b0001, 16'h3001, p_b,    1'b0, 1'b1, 4'b0000, 4'h1, 32'h11110000, 2'd0, 16'd2};
    vecs[9]  = '{4'b0000, 16'h0000, 128'h0, 1'b1, 1'b0, 4'b0001, 4'h1, 32'h11110000, 2'd0, 16'd3};
    vecs[10] = '{4'b0000, 16'h0000, 128'h0, 1'b1, 1'b0, 4'b0000, 4'h1, 32'h11110000, 2'd0, 16'd3};

    // Reset state
    do_reset();
    check_all("reset", 1'b0, 4'b0000, 4'h0, 32'h0, 2'd0, 16'd0);

    // Table: single request, pointer wrap 3 -> 0, short backpressure
    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vecs[i].vld, vecs[i].addr, vecs[i].payload, vecs[i].ready);
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_granted,
                vecs[i].exp_addr, vecs[i].exp_payload, vecs[i].exp_src, vecs[i].exp_count);
    end

    // Round robin: all four ports request, each drops its bit on its grant
    do_reset();
    mask      = 4'b1111;
    grant_idx = 0;
    for (int c = 0; c < 12; c++) begin
      apply_stimulus(mask, 16'h7654, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b1);
      tick();
      if (bus.out_valid && grant_idx < 4) begin
        check_output("rr out_payload", bus.out_payload, 32'hA0 + 32'(grant_idx));
        check_output("rr out_addr", 32'(bus.out_addr), 32'(4 + grant_idx));
      end
      if (bus.granted != 4'b0000) begin
        check_output("rr granted", 32'(bus.granted), 32'(1) << grant_idx);
        mask = mask & ~bus.granted;
        grant_idx++;
      end
    end
    check_output("rr grant total", 32'(grant_idx), 32'd4);
    check_output("rr pkt_count", 32'(bus.pkt_count), 32'd4);

    // Backpressure: five stalled cycles in SEND, then the handshake
    do_reset();
    apply_stimulus(4'b0010, 16'h0070, {64'h0, 32'h12345678, 32'h0}, 1'b0);
    tick();
    check_all("bp load", 1'b1, 4'b0000, 4'h7, 32'h12345678, 2'd1, 16'd0);
    for (int c = 0; c < 5; c++) begin
      apply_stimulus(4'b0000, 16'h0, 128'h0, 1'b0);
      tick();
      check_all($sformatf("bp stall%0d", c), 1'b1, 4'b0000, 4'h7, 32'h12345678, 2'd1, 16'd0);
    end
    apply_stimulus(4'b0000, 16'h0, 128'h0, 1'b1);
    tick();
    check_all("bp handshake", 1'b0, 4'b0010, 4'h7, 32'h12345678, 2'd1, 16'd1);
    tick();
    check_output("bp grant end", 32'(bus.granted), 32'd0);

    // Reset mid-SEND with ptr at 2: packet discarded, next arbitration from port 0
    apply_stimulus(4'b1000, 16'h9000, {32'hCAFEF00D, 96'h0}, 1'b0);
    tick();
    check_all("mid load", 1'b1, 4'b0000, 4'h9, 32'hCAFEF00D, 2'd3, 16'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all("mid async", 1'b0, 4'b0000, 4'h0, 32'h0, 2'd0, 16'd0);
    apply_stimulus(4'b0000, 16'h0, 128'h0, 1'b1);
    tick();
    check_output("mid no grant", 32'(bus.granted), 32'd0);
    reset_n = 1'b1;
    apply_stimulus(4'b1010, 16'h00B0, {32'h0000B3B3, 32'h0, 32'h0000B0B1, 32'h0}, 1'b1);
    tick();
    check_all("post reset", 1'b1, 4'b0000, 4'hB, 32'h0000B0B1, 2'd1, 16'd0);
    apply_stimulus(4'b0000, 16'h0, 128'h0, 1'b1);
    tick();
    check_all("post hs", 1'b0, 4'b0010, 4'hB, 32'h0000B0B1, 2'd1, 16'd1);
    tick();

    // Counter wrap: preload 16'hFFFF, one more handshake rolls to zero
    force dut.pkt_count_q = 16'hFFFF;
    #1;
    release dut.pkt_count_q;
    #1;
    check_output("wrap preload", 32'(bus.pkt_count), 32'h0000FFFF);
    apply_stimulus(4'b0100, 16'h0C00, {32'h0, 32'h0C0C0C0C, 64'h0}, 1'b1);
    tick();
    check_all("wrap load", 1'b1, 4'b0000, 4'hC, 32'h0C0C0C0C, 2'd2, 16'hFFFF);
    apply_stimulus(4'b0000, 16'h0, 128'h0, 1'b1);
    tick();
    check_all("wrap hs", 1'b0, 4'b0100, 4'hC, 32'h0C0C0C0C, 2'd2, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
